// File: rtl/id_ex_stage.sv
// ID/EX pipeline register plus EX operand selection: MEM/WB forwarding, load-use stall, shift-amount masking.
// Optional perf counters (StallCnt/FlushCnt) are built when IDEX_PERF_CNT_EN is defined.
module id_ex_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ValidD,
    input  logic [XLEN-1:0]       RD1D,
    input  logic [XLEN-1:0]       RD2D,
    input  logic [XLEN-1:0]       ImmExtD,
    input  logic [XLEN-1:0]       PCD,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    input  logic [REG_ADDR_W-1:0] RdD,
    input  logic                  RegWriteD,
    input  logic                  MemWriteD,
    input  logic [1:0]            ResultSrcD,
    input  logic                  ALUSrcD,
    input  logic [2:0]            ALUControlD,
    input  logic                  FlushE,
    input  logic [REG_ADDR_W-1:0] RdM,
    input  logic [REG_ADDR_W-1:0] RdW,
    input  logic                  RegWriteM,
    input  logic                  RegWriteW,
    input  logic [XLEN-1:0]       ALUResultM,
    input  logic [XLEN-1:0]       ResultW,
    output logic [XLEN-1:0]       SrcAE,
    output logic [XLEN-1:0]       SrcBE,
    output logic [XLEN-1:0]       WriteDataE,
    output logic [2:0]            ALUControlE,
    output logic [REG_ADDR_W-1:0] RdE,
    output logic                  RegWriteE,
    output logic                  MemWriteE,
    output logic [1:0]            ResultSrcE,
    output logic [XLEN-1:0]       PCE,
    output logic                  ValidE,
`ifdef IDEX_PERF_CNT_EN
    output logic [31:0]           StallCnt,
    output logic [31:0]           FlushCnt,
`endif
    output logic                  LoadUseStall
);

    logic                  valid_q, regwrite_q, memwrite_q, alusrc_q;
    logic [XLEN-1:0]       rd1_q, rd2_q, imm_q, pc_q;
    logic [REG_ADDR_W-1:0] rs1_q, rs2_q, rd_q;
    logic [1:0]            resultsrc_q;
    logic [2:0]            aluctl_q;
    logic                  bubble;

    assign LoadUseStall = valid_q & ValidD & regwrite_q & (resultsrc_q == 2'b01)
                        & (rd_q != '0) & ((rd_q == Rs1D) | (rd_q == Rs2D));
    assign bubble = FlushE | LoadUseStall;

    // A bubble zeroes every E field, so Rs1E/Rs2E become x0 and nothing forwards into it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || bubble) begin
            valid_q     <= 1'b0;
            regwrite_q  <= 1'b0;
            memwrite_q  <= 1'b0;
            alusrc_q    <= 1'b0;
            rd1_q       <= '0;
            rd2_q       <= '0;
            imm_q       <= '0;
            pc_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            resultsrc_q <= '0;
            aluctl_q    <= '0;
        end else begin
            valid_q     <= ValidD;
            regwrite_q  <= RegWriteD;
            memwrite_q  <= MemWriteD;
            alusrc_q    <= ALUSrcD;
            rd1_q       <= RD1D;
            rd2_q       <= RD2D;
            imm_q       <= ImmExtD;
            pc_q        <= PCD;
            rs1_q       <= Rs1D;
            rs2_q       <= Rs2D;
            rd_q        <= RdD;
            resultsrc_q <= ResultSrcD;
            aluctl_q    <= ALUControlD;
        end
    end

    logic [XLEN-1:0] fwd_a, fwd_b, srcb_raw;
    logic            m_ok, w_ok, shift_op;

    assign m_ok = RegWriteM & (RdM != '0);
    assign w_ok = RegWriteW & (RdW != '0);

    // MEM is the younger producer, so it takes priority over WB.
    always_comb begin
        fwd_a = rd1_q;
        if (m_ok && RdM == rs1_q)      fwd_a = ALUResultM;
        else if (w_ok && RdW == rs1_q) fwd_a = ResultW;
        fwd_b = rd2_q;
        if (m_ok && RdM == rs2_q)      fwd_b = ALUResultM;
        else if (w_ok && RdW == rs2_q) fwd_b = ResultW;
    end

    assign shift_op = aluctl_q[2] & (|aluctl_q[1:0]);
    assign srcb_raw = alusrc_q ? imm_q : fwd_b;
    assign SrcBE    = shift_op ? {{(XLEN-5){1'b0}}, srcb_raw[4:0]} : srcb_raw;

    assign SrcAE       = fwd_a;
    assign WriteDataE  = fwd_b;
    assign ALUControlE = aluctl_q;
    assign RdE         = rd_q;
    assign RegWriteE   = regwrite_q;
    assign MemWriteE   = memwrite_q;
    assign ResultSrcE  = resultsrc_q;
    assign PCE         = pc_q;
    assign ValidE      = valid_q;

`ifdef IDEX_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    // Flushes coinciding with a stall are attributed to the stall only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (LoadUseStall && stall_cnt_q != 32'hFFFF_FFFF)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (FlushE && !LoadUseStall && flush_cnt_q != 32'hFFFF_FFFF)
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;
`endif

endmodule
